// File: rtl/clk_ce_pkg.sv
// clk_ce_pkg: shared mode constants, state encoding and default increments
// for the fractional clock-enable generator.
package clk_ce_pkg;

  localparam logic MODE_NTSC = 1'b0;
  localparam logic MODE_PAL  = 1'b1;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_SETTLE,
    ST_LOCKED,
    ST_PEND
  } state_e;

  localparam longint unsigned BOARD_CLK_HZ = 64'd100_000_000;

  // inc = f_out * 2^32 / f_clk for a 32-bit accumulator
  function automatic logic [31:0] calc_inc(
    input longint unsigned f_hz,
    input longint unsigned clk_hz
  );
    longint unsigned tmp;
    tmp = (f_hz << 32) / clk_hz;
    return tmp[31:0];
  endfunction

  localparam logic [31:0] INC_NTSC_CPU = calc_inc(64'd3_579_545, BOARD_CLK_HZ);
  localparam logic [31:0] INC_NTSC_AUD = calc_inc(64'd53_267, BOARD_CLK_HZ);
  localparam logic [31:0] INC_PAL_CPU  = calc_inc(64'd3_546_895, BOARD_CLK_HZ);
  localparam logic [31:0] INC_PAL_AUD  = calc_inc(64'd52_781, BOARD_CLK_HZ);

  localparam logic [63:0] DEF_INC_NTSC = {INC_NTSC_AUD, INC_NTSC_CPU};
  localparam logic [63:0] DEF_INC_PAL  = {INC_PAL_AUD, INC_PAL_CPU};

endpackage

// File: rtl/clk_ce_nco.sv
// clk_ce_nco: one phase-accumulator channel with increment load and
// accumulator clear; the wrap carry becomes a registered one-cycle strobe.
module clk_ce_nco
  import clk_ce_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             clr_i,
  input  logic [ACC_W-1:0] inc_i,
  output logic             carry_o,
  output logic             ce_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] inc_q, inc_d;
  logic             ce_q, ce_d;
  logic [ACC_W:0]   sum;

  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, inc_q};
    carry_o = sum[ACC_W];
    ce_d    = sum[ACC_W];
    acc_d   = clr_i ? '0 : sum[ACC_W-1:0];
    inc_d   = load_i ? inc_i : inc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      inc_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      inc_q <= inc_d;
      ce_q  <= ce_d;
    end
  end

  assign ce_o = ce_q;

endmodule

// File: rtl/clk_ce_synth.sv
// clk_ce_synth: NUM_CH NCO clock enables with NTSC/PAL switching on a
// channel-0 boundary. CLK_CE_GATE_UNLOCKED_EN masks ce_out while unlocked.
module clk_ce_synth
  import clk_ce_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int ACC_W          = 32,
  parameter int SETTLE_CYCLES  = 1024,
  parameter int SWITCH_TIMEOUT = 65535,
  parameter int DEF_MODE       = 0
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic [NUM_CH*ACC_W-1:0] inc_ntsc,
  input  logic [NUM_CH*ACC_W-1:0] inc_pal,
  input  logic                    mode_req,
  output logic [NUM_CH-1:0]       ce_out,
  output logic                    mode_cur,
  output logic                    switching,
  output logic                    locked
);

  localparam int   SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int   TO_W  = $clog2(SWITCH_TIMEOUT + 1);
  localparam logic DEF_M = DEF_MODE[0];

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic               sw_q, sw_d;
  logic               lk_q, lk_d;
  logic               load, clr;
  logic [NUM_CH*ACC_W-1:0] inc_sel;
  logic [NUM_CH-1:0]  wrap;
  logic [NUM_CH-1:0]  ce_raw;
  logic               unused_wrap;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    settle_d = settle_q;
    to_d     = to_q;
    sw_d     = sw_q;
    lk_d     = lk_q;
    load     = 1'b0;
    clr      = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        load     = 1'b1;
        clr      = 1'b1;
        settle_d = '0;
        sw_d     = 1'b0;
        lk_d     = 1'b0;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
          state_d = ST_LOCKED;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_LOCKED: begin
        lk_d = 1'b1;
        sw_d = 1'b0;
        if (mode_req != mode_q) begin
          state_d = ST_PEND;
          sw_d    = 1'b1;
          to_d    = '0;
        end
      end
      ST_PEND: begin
        // cancel has priority over a coincident boundary
        if (mode_req == mode_q) begin
          state_d = ST_LOCKED;
          sw_d    = 1'b0;
        end else if (wrap[0] || to_q == TO_W'(SWITCH_TIMEOUT - 1)) begin
          mode_d   = mode_req;
          load     = 1'b1;
          clr      = 1'b1;
          lk_d     = 1'b0;
          settle_d = '0;
          state_d  = ST_SETTLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign inc_sel = mode_d ? inc_pal : inc_ntsc;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_INIT;
      mode_q   <= DEF_M;
      settle_q <= '0;
      to_q     <= '0;
      sw_q     <= 1'b0;
      lk_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      settle_q <= settle_d;
      to_q     <= to_d;
      sw_q     <= sw_d;
      lk_q     <= lk_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_ce_nco #(
      .ACC_W(ACC_W)
    ) u_nco (
      .clk     (clk_sys),
      .rst_n   (reset_n),
      .load_i  (load),
      .clr_i   (clr),
      .inc_i   (inc_sel[i*ACC_W +: ACC_W]),
      .carry_o (wrap[i]),
      .ce_o    (ce_raw[i])
    );
  end

  // only channel 0 marks the switch boundary
  assign unused_wrap = ^wrap;

`ifdef CLK_CE_GATE_UNLOCKED_EN
  assign ce_out = ce_raw & {NUM_CH{lk_q}};
`else
  assign ce_out = ce_raw;
`endif

  assign mode_cur  = mode_q;
  assign switching = sw_q;
  assign locked    = lk_q;

endmodule

// File: tb/tb_clk_ce_synth.sv
// tb_clk_ce_synth: directed checks of rate, switch, cancel, timeout
// and mid-switch reset for clk_ce_synth (ACC_W=8, two channels).
module tb_clk_ce_synth;

`ifdef CLK_CE_GATE_UNLOCKED_EN
  localparam logic GATED = 1'b1;
`else
  localparam logic GATED = 1'b0;
`endif
  localparam logic [31:0] SET_CE = GATED ? 32'd0 : 32'd1;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] inc_ntsc;
  logic [15:0] inc_pal;
  logic        mode_req;
  logic [1:0]  ce_out;
  logic        mode_cur;
  logic        switching;
  logic        locked;

  int checks = 0;
  int errors = 0;
  int e = 0;
  int n0 = 0;
  int n1 = 0;

  always #5 clk_sys = ~clk_sys;

  clk_ce_synth #(
    .NUM_CH         (2),
    .ACC_W          (8),
    .SETTLE_CYCLES  (8),
    .SWITCH_TIMEOUT (20),
    .DEF_MODE       (0)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .inc_ntsc  (inc_ntsc),
    .inc_pal   (inc_pal),
    .mode_req  (mode_req),
    .ce_out    (ce_out),
    .mode_cur  (mode_cur),
    .switching (switching),
    .locked    (locked)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick_to(input int t);
    while (e < t) begin
      @(posedge clk_sys);
      #1;
      e++;
      n0 += int'(ce_out[0]);
      n1 += int'(ce_out[1]);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ce"}, 32'(ce_out), 32'd0);
    chk({tag, "_mode"}, 32'(mode_cur), 32'd0);
    chk({tag, "_sw"}, 32'(switching), 32'd0);
    chk({tag, "_lock"}, 32'(locked), 32'd0);
  endtask

  initial begin
    inc_ntsc = {8'd128, 8'd64};
    inc_pal  = {8'd80, 8'd32};
    mode_req = 1'b0;
    #12;
    chk_reset("rst");
    @(negedge clk_sys);
    reset_n = 1'b1;
    e = 0;

    tick_to(3);
    chk("settle_ce1", 32'(ce_out[1]), SET_CE);
    tick_to(4);
    chk("settle_ce0_lo", 32'(ce_out[0]), 32'd0);
    tick_to(5);
    chk("settle_ce0", 32'(ce_out[0]), SET_CE);
    chk("settle_sw_init", 32'(switching), 32'd0);
    tick_to(9);
    chk("lock_lo", 32'(locked), 32'd0);
    tick_to(10);
    chk("lock_hi", 32'(locked), 32'd1);
    chk("lock_sw", 32'(switching), 32'd0);

    n0 = 0; n1 = 0;
    tick_to(26);
    chk("rate_ch0", 32'(n0), 32'd4);
    chk("rate_ch1", 32'(n1), 32'd8);

    mode_req = 1'b1;
    tick_to(27);
    chk("pend_sw", 32'(switching), 32'd1);
    chk("pend_lock", 32'(locked), 32'd1);
    chk("pend_mode", 32'(mode_cur), 32'd0);
    tick_to(28);
    chk("pend_mode2", 32'(mode_cur), 32'd0);
    n0 = 0; n1 = 0;
    tick_to(29);
    chk("commit_mode", 32'(mode_cur), 32'd1);
    chk("commit_ce0", 32'(ce_out[0]), SET_CE);
    chk("commit_lock", 32'(locked), 32'd0);
    chk("commit_sw", 32'(switching), 32'd1);

    n0 = 0; n1 = 0;
    tick_to(37);
    chk("pal_settle_lock", 32'(locked), 32'd0);
    chk("pal_settle_sw", 32'(switching), 32'd1);
    chk("pal_settle_ce0", 32'(ce_out[0]), SET_CE);
    tick_to(38);
    chk("pal_lock", 32'(locked), 32'd1);
    chk("pal_sw", 32'(switching), 32'd0);
    tick_to(45);
    chk("pal_rate_ch0", 32'(n0), GATED ? 32'd1 : 32'd2);
    chk("pal_rate_ch1", 32'(n1), GATED ? 32'd3 : 32'd5);

    tick_to(46);
    mode_req = 1'b0;
    tick_to(47);
    chk("cancel_sw_hi", 32'(switching), 32'd1);
    chk("cancel_lock1", 32'(locked), 32'd1);
    mode_req = 1'b1;
    tick_to(48);
    chk("cancel_sw_lo", 32'(switching), 32'd0);
    chk("cancel_lock2", 32'(locked), 32'd1);
    chk("cancel_mode", 32'(mode_cur), 32'd1);
    tick_to(52);
    chk("cancel_ce0_lo", 32'(ce_out[0]), 32'd0);
    tick_to(53);
    chk("cancel_ce0_hi", 32'(ce_out[0]), 32'd1);

    tick_to(59);
    mode_req = 1'b0;
    tick_to(60);
    chk("race_sw_hi", 32'(switching), 32'd1);
    mode_req = 1'b1;
    tick_to(61);
    chk("race_ce0", 32'(ce_out[0]), 32'd1);
    chk("race_mode", 32'(mode_cur), 32'd1);
    chk("race_sw_lo", 32'(switching), 32'd0);
    chk("race_lock", 32'(locked), 32'd1);

    #2;
    reset_n  = 1'b0;
    inc_ntsc = {8'd128, 8'd0};
    mode_req = 1'b0;
    #1;
    chk_reset("rst2");
    @(negedge clk_sys);
    reset_n = 1'b1;
    e = 0;
    tick_to(10);
    chk("to_lock", 32'(locked), 32'd1);
    mode_req = 1'b1;
    tick_to(11);
    chk("to_pend_sw", 32'(switching), 32'd1);
    tick_to(30);
    chk("to_wait_mode", 32'(mode_cur), 32'd0);
    chk("to_wait_lock", 32'(locked), 32'd1);
    tick_to(31);
    chk("to_commit_mode", 32'(mode_cur), 32'd1);
    chk("to_commit_lock", 32'(locked), 32'd0);

    tick_to(35);
    chk("mid_ce1", 32'(ce_out[1]), SET_CE);
    chk("mid_sw", 32'(switching), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset("rst3");
    @(negedge clk_sys);
    reset_n = 1'b1;
    e = 0;
    tick_to(2);
    chk("post_mode", 32'(mode_cur), 32'd0);
    chk("post_lock", 32'(locked), 32'd0);
    tick_to(10);
    chk("post_lock_hi", 32'(locked), 32'd1);
    chk("post_mode2", 32'(mode_cur), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
